mem_port_arbiter: RTL and testbench

Shares the single external memory port between the fetch stage (instruction reads) and the memory-access stage (data reads/writes). It sequences one external transaction at a time with a req/ack handshake, returns read data to the owning requester and produces the `fetch_done` / `mem_done` levels consumed by the pipeline controller. It also cancels in-flight fetches on flush without corrupting the bus.

---
 rtl/mem_port_arbiter_if.sv | 48 ++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data-stage and external-memory signals of mem_port_arbiter.
// slave is the arbiter's view; master is the view of the pipeline plus external memory.
interface mem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_flush;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_done;

    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [DATA_WIDTH-1:0] dm_wdata;
    logic [3:0]            dm_sel;
    logic [DATA_WIDTH-1:0] dm_rdata;
    logic                  dm_done;

    // Handshake: ext_req rises with ext_* already valid and holds them stable until
    // the single-cycle ext_ack; ext_rdata is only meaningful in the ack cycle.
    // ext_ack seen while ext_req is low is ignored.
    logic                  ext_req;
    logic                  ext_we;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic [3:0]            ext_sel;
    logic                  ext_ack;
    logic [DATA_WIDTH-1:0] ext_rdata;

    // FSM state for observation: 0 IDLE, 1 FETCH, 2 DATA, 3 DRAIN
    logic [1:0]            dbg_state;

    modport slave (
        input  if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_sel,
               ext_ack, ext_rdata,
        output if_rdata, if_done, dm_rdata, dm_done,
               ext_req, ext_we, ext_addr, ext_wdata, ext_sel, dbg_state
    );

    modport master (
        output if_req, if_addr, if_flush, dm_req, dm_we, dm_addr, dm_wdata, dm_sel,
               ext_ack, ext_rdata,
        input  if_rdata, if_done, dm_rdata, dm_done,
               ext_req, ext_we, ext_addr, ext_wdata, ext_sel, dbg_state
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between instruction fetch and the data stage.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate on contention instead of data-first.
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]            state;
    logic                  hf_valid;
    logic [ADDR_WIDTH-1:0] hf_addr;
    logic                  hd_valid;
    logic                  hd_we;
    logic [ADDR_WIDTH-1:0] hd_addr;
    logic [DATA_WIDTH-1:0] ack_data;

    logic if_hit;
    logic dm_hit;
    logic if_pend;
    logic dm_pend;
    logic grant_fetch;
    logic grant_data;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_data;
`endif

    assign ack_data = bus.ext_rdata;

    always_comb begin
        if_hit  = hf_valid && (bus.if_addr == hf_addr);
        dm_hit  = hd_valid && (bus.dm_addr == hd_addr) && (bus.dm_we == hd_we);
        // A fetch under flush is being discarded, so it never competes for the bus
        if_pend = bus.if_req && !bus.if_flush && !if_hit;
        dm_pend = bus.dm_req && !dm_hit;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        grant_fetch = if_pend && (!dm_pend || last_data);
`else
        grant_fetch = if_pend && !dm_pend;
`endif
        grant_data = dm_pend && !grant_fetch;
    end

    assign bus.if_done   = bus.if_req && if_hit;
    assign bus.dm_done   = !bus.dm_req || dm_hit;
    assign bus.dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            hf_valid      <= 1'b0;
            hf_addr       <= '0;
            hd_valid      <= 1'b0;
            hd_we         <= 1'b0;
            hd_addr       <= '0;
            bus.ext_req   <= 1'b0;
            bus.ext_we    <= 1'b0;
            bus.ext_addr  <= '0;
            bus.ext_wdata <= '0;
            bus.ext_sel   <= 4'h0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_data     <= 1'b1;
`endif
        end else begin
            // Held results last only while the requester keeps asking for the same access
            if (hf_valid && (!bus.if_req || !if_hit || bus.if_flush))
                hf_valid <= 1'b0;
            if (hd_valid && (!bus.dm_req || !dm_hit))
                hd_valid <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (grant_fetch) begin
                        bus.ext_req  <= 1'b1;
                        bus.ext_we   <= 1'b0;
                        bus.ext_addr <= bus.if_addr;
                        bus.ext_sel  <= 4'hF;
                        state        <= S_FETCH;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_data    <= 1'b0;
`endif
                    end else if (grant_data) begin
                        bus.ext_req   <= 1'b1;
                        bus.ext_we    <= bus.dm_we;
                        bus.ext_addr  <= bus.dm_addr;
                        bus.ext_wdata <= bus.dm_wdata;
                        bus.ext_sel   <= bus.dm_sel;
                        state         <= S_DATA;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_data     <= 1'b1;
`endif
                    end
                end
                S_FETCH: begin
                    // Flush beats a same-cycle ack: the returned word is dropped
                    if (bus.if_flush) begin
                        if (bus.ext_ack) begin
                            bus.ext_req <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (bus.ext_ack) begin
                        bus.if_rdata <= ack_data;
                        hf_valid     <= 1'b1;
                        hf_addr      <= bus.ext_addr;
                        bus.ext_req  <= 1'b0;
                        state        <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (bus.ext_ack) begin
                        if (!bus.ext_we)
                            bus.dm_rdata <= ack_data;
                        hd_valid    <= 1'b1;
                        hd_addr     <= bus.ext_addr;
                        hd_we       <= bus.ext_we;
                        bus.ext_req <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (bus.ext_ack) begin
                        bus.ext_req <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter: a memory responder, a reference
// model of grant order and memory contents, and monitors on the external bus and done levels.
module tb_mem_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]    sel;
    } ext_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    ext_t          exp_ext_q[$];
    logic [DW-1:0] exp_if_q[$];
    logic [DW-1:0] exp_dm_q[$];
    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] model_mem [logic [AW-1:0]];
    logic [DW-1:0] ext_mem   [logic [AW-1:0]];
    logic [DW-1:0] last_dm = '0;
    bit            last_served_data = 1'b1;

    int force_delay = -1;
    int resp_cnt = -1;
    bit inject_ack = 1'b0;

    logic prev_req = 1'b0;
    logic prev_if = 1'b0;
    logic prev_dm = 1'b0;
    ext_t cur_e;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                            input logic [3:0] sel);
        logic [DW-1:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++)
            if (sel[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] ext_read(input logic [AW-1:0] a);
        return ext_mem.exists(a) ? ext_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- external memory responder ----------------
    initial begin
        bus.ext_ack = 1'b0;
        bus.ext_rdata = '0;
        forever begin
            @(negedge clk);
            bus.ext_ack = 1'b0;
            if (inject_ack) begin
                bus.ext_ack = 1'b1;
                bus.ext_rdata = 32'hBAD0_BAD0;
            end else if (!rst_n) begin
                resp_cnt = -1;
            end else if (bus.ext_req) begin
                if (resp_cnt < 0)
                    resp_cnt = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
                if (resp_cnt == 0) begin
                    bus.ext_ack = 1'b1;
                    if (bus.ext_we) begin
                        ext_mem[bus.ext_addr] = merge(ext_read(bus.ext_addr), bus.ext_wdata, bus.ext_sel);
                        bus.ext_rdata = $urandom;
                    end else begin
                        bus.ext_rdata = ext_read(bus.ext_addr);
                    end
                    resp_cnt = -1;
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        ext_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                prev_if = 1'b0;
                prev_dm = 1'b0;
            end else begin
                if (bus.ext_req && !prev_req) begin
                    if (exp_ext_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL ext_unexpected: got addr %0h we %0b, expected no transaction", bus.ext_addr, bus.ext_we);
                    end else begin
                        e = exp_ext_q.pop_front();
                        cur_e = e;
                        check("ext_we", bus.ext_we, e.we);
                        check("ext_addr", bus.ext_addr, e.addr);
                        check("ext_sel", bus.ext_sel, e.sel);
                        if (e.we) check("ext_wdata", bus.ext_wdata, e.wdata);
                    end
                end else if (bus.ext_req) begin
                    check("ext_stable", {bus.ext_we, bus.ext_addr, bus.ext_sel}, {cur_e.we, cur_e.addr, cur_e.sel});
                end
                prev_req = bus.ext_req;

                if (bus.if_req && bus.if_done && !prev_if) begin
                    if (exp_if_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL if_done_unexpected: got if_done 1 addr %0h, expected 0", bus.if_addr);
                    end else begin
                        check("if_rdata", bus.if_rdata, exp_if_q.pop_front());
                    end
                end
                prev_if = bus.if_req && bus.if_done;

                if (bus.dm_req && bus.dm_done && !prev_dm) begin
                    if (exp_dm_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL dm_done_unexpected: got dm_done 1 addr %0h, expected 0", bus.dm_addr);
                    end else begin
                        check("dm_rdata", bus.dm_rdata, exp_dm_q.pop_front());
                    end
                end
                prev_dm = bus.dm_req && bus.dm_done;
            end
        end
    end

    // ---------------- reference model ----------------
    task automatic model_fetch(input logic [AW-1:0] fa);
        ext_t e;
        e.we = 1'b0;
        e.addr = fa;
        e.wdata = '0;
        e.sel = 4'hF;
        exp_ext_q.push_back(e);
        exp_if_q.push_back(model_read(fa));
        last_served_data = 1'b0;
    endtask

    task automatic model_data(input bit we, input logic [AW-1:0] da, input logic [DW-1:0] wd,
                              input logic [3:0] sel);
        ext_t e;
        e.we = we;
        e.addr = da;
        e.wdata = wd;
        e.sel = sel;
        exp_ext_q.push_back(e);
        if (we) model_mem[da] = merge(model_read(da), wd, sel);
        else last_dm = model_read(da);
        exp_dm_q.push_back(last_dm);
        last_served_data = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic run_op(input bit f, input bit d, input logic [AW-1:0] fa, input bit we,
                          input logic [AW-1:0] da, input logic [DW-1:0] wd, input logic [3:0] sel,
                          input int hold, output int lat);
        bit fetch_first;
        bit done;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        fetch_first = f && (!d || last_served_data);
`else
        fetch_first = f && !d;
`endif
        if (fetch_first) begin
            model_fetch(fa);
            if (d) model_data(we, da, wd, sel);
        end else begin
            if (d) model_data(we, da, wd, sel);
            if (f) model_fetch(fa);
        end
        @(negedge clk);
        bus.if_req = f;
        bus.if_addr = fa;
        bus.dm_req = d;
        bus.dm_we = we;
        bus.dm_addr = da;
        bus.dm_wdata = wd;
        bus.dm_sel = sel;
        lat = 0;
        done = 1'b0;
        while (!done && lat < 80) begin
            @(negedge clk);
            lat++;
            done = (!f || bus.if_done) && (!d || bus.dm_done);
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL op_timeout: got no done after %0d cycles, expected done", lat);
        end
        repeat (hold) begin
            @(negedge clk);
            if (f) check("if_done_hold", bus.if_done, 1'b1);
            if (d) check("dm_done_hold", bus.dm_done, 1'b1);
        end
        @(negedge clk);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic flush_test(input int k, input int ack_delay, input logic [AW-1:0] a0);
        ext_t e;
        int n;
        force_delay = ack_delay;
        e.we = 1'b0;
        e.addr = a0;
        e.wdata = '0;
        e.sel = 4'hF;
        exp_ext_q.push_back(e);
        last_served_data = 1'b0;
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = a0;
        repeat (k) @(negedge clk);
        bus.if_flush = 1'b1;
        bus.if_addr = 32'h300;
        model_fetch(32'h300);
        @(negedge clk);
        bus.if_flush = 1'b0;
        force_delay = -1;
        check("flush_if_done", bus.if_done, 1'b0);
        if (ack_delay + 1 > k) begin
            check("drain_ext_req", bus.ext_req, 1'b1);
            check("drain_ext_addr", bus.ext_addr, a0);
        end else begin
            check("flush_ack_ext_req", bus.ext_req, 1'b0);
        end
        n = 0;
        while (!bus.if_done && n < 80) begin
            @(negedge clk);
            n++;
        end
        check("refetch_done", bus.if_done, 1'b1);
        @(negedge clk);
        bus.if_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic reset_test();
        ext_t e;
        force_delay = 8;
        e.we = 1'b0;
        e.addr = 32'h8000;
        e.wdata = '0;
        e.sel = 4'hF;
        exp_ext_q.push_back(e);
        @(negedge clk);
        bus.dm_req = 1'b1;
        bus.dm_we = 1'b0;
        bus.dm_addr = 32'h8000;
        bus.dm_sel = 4'hF;
        repeat (3) @(negedge clk);
        check("pre_reset_ext_req", bus.ext_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ext_req", bus.ext_req, 1'b0);
        check("rst_ext_addr", bus.ext_addr, 32'h0);
        check("rst_ext_sel", bus.ext_sel, 4'h0);
        check("rst_dm_rdata", bus.dm_rdata, 32'h0);
        check("rst_if_rdata", bus.if_rdata, 32'h0);
        check("rst_dm_done_pending", bus.dm_done, 1'b0);
        force_delay = -1;
        last_dm = '0;
        last_served_data = 1'b1;
        @(negedge clk);
        bus.dm_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 inject_ack = 1'b1;
        @(posedge clk);
        #1 inject_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_ext_req", bus.ext_req, 1'b0);
        check("stray_ack_dm_rdata", bus.dm_rdata, 32'h0);
        check("stray_ack_if_rdata", bus.if_rdata, 32'h0);
        check("stray_ack_state", bus.dbg_state, 2'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.if_flush = 1'b0;
        bus.dm_req = 1'b0;
        bus.dm_we = 1'b0;
        bus.dm_addr = '0;
        bus.dm_wdata = '0;
        bus.dm_sel = 4'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_ext_req", bus.ext_req, 1'b0);
        check("reset_ext_we", bus.ext_we, 1'b0);
        check("reset_ext_addr", bus.ext_addr, 32'h0);
        check("reset_ext_wdata", bus.ext_wdata, 32'h0);
        check("reset_ext_sel", bus.ext_sel, 4'h0);
        check("reset_if_rdata", bus.if_rdata, 32'h0);
        check("reset_dm_rdata", bus.dm_rdata, 32'h0);
        check("reset_if_done", bus.if_done, 1'b0);
        check("reset_dm_done", bus.dm_done, 1'b1);
        check("reset_state", bus.dbg_state, 2'd0);

        force_delay = 3;
        run_op(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 32'h0, 4'hF, 3, lat);
        check("fetch_latency", lat, 5);
        force_delay = 0;
        run_op(1'b0, 1'b1, 32'h0, 1'b0, 32'h8000, 32'h0, 4'hF, 1, lat);
        check("data_min_latency", lat, 2);
        force_delay = -1;

        repeat (3) run_op(1'b1, 1'b1, 32'h200, 1'b0, 32'h8000, 32'h0, 4'hF, 1, lat);

        run_op(1'b0, 1'b1, 32'h0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 5, lat);
        run_op(1'b0, 1'b1, 32'h0, 1'b0, 32'h40, 32'h0, 4'hF, 0, lat);

        flush_test(2, 4, 32'h500);
        flush_test(3, 2, 32'h600);

        reset_test();
        repeat (2) run_op(1'b1, 1'b1, 32'h200, 1'b0, 32'h8000, 32'h0, 4'hF, 0, lat);

        for (int i = 0; i < 60; i++) begin
            bit f, d, we;
            logic [AW-1:0] fa, da;
            f = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            if (!f && !d) f = 1'b1;
            we = 1'($urandom_range(0, 1));
            fa = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            da = 32'h1000 + 32'(4 * $urandom_range(0, 7));
            run_op(f, d, fa, we, da, $urandom, 4'($urandom_range(1, 15)), int'($urandom_range(0, 3)), lat);
        end

        repeat (5) @(negedge clk);
        check("ext_queue_drained", exp_ext_q.size(), 0);
        check("if_queue_drained", exp_if_q.size(), 0);
        check("dm_queue_drained", exp_dm_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no completion by %0t, expected finish", $time);
        $fatal(1, "timeout");
    end
endmodule
